// File: rtl/digit_display_pkg.sv
// Shared constants for the six-digit multiplexed seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package digit_display_pkg;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_SET   = 4'd1,
    ST_START = 4'd3
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam int NUM_DIGITS = 6;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  localparam logic [2:0] COLON_POS_A = 3'd2;
  localparam logic [2:0] COLON_POS_B = 3'd4;

  function automatic logic is_colon(input logic [2:0] pos);
    return (pos == COLON_POS_A) || (pos == COLON_POS_B);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show a dash.
import digit_display_pkg::*;

module bcd_to_seg7 (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_display_scanner.sv
// Time-multiplexed common-anode driver for an HH:MM:SS display with per-frame snapshot.
// Optional hour-tens leading-zero blanking: define DIGIT_DISPLAY_LZ_BLANK_EN.
import digit_display_pkg::*;

module digit_display_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [3:0]  state,
  input  logic [23:0] currentBits,
  input  logic [2:0]  setSelect,
  output logic [5:0]  anodeN,
  output logic [6:0]  segN,
  output logic        dpN,
  output logic        frameDone
);

  localparam int PS_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);
  localparam int FC_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [PS_W-1:0] prescaler_reg;
  logic [2:0]      idx_reg;
  logic [23:0]     frame_reg;
  logic [FC_W-1:0] frame_cnt_reg;
  logic            blink_phase_reg;
  logic [5:0]      anode_reg;
  logic [6:0]      seg_reg;
  logic            dp_reg;
  logic            frame_done_reg;

  logic            tick;
  logic [3:0]      digits [NUM_DIGITS];
  logic [3:0]      digit_val;
  logic [6:0]      seg_decoded;
  logic            blink_blank;
  logic            lz_blank;
  logic [5:0]      anode_next;
  logic [6:0]      seg_next;
  logic            dp_next;

  assign tick = (prescaler_reg == PS_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
      assign digits[gi] = frame_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    digit_val = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == 3'(i)) digit_val = digits[i];
    end
  end

  bcd_to_seg7 u_dec (
    .digit (digit_val),
    .seg   (seg_decoded)
  );

  always_comb begin
    blink_blank = (state == ST_SET) && (idx_reg == setSelect) && blink_phase_reg;
`ifdef DIGIT_DISPLAY_LZ_BLANK_EN
    lz_blank = (idx_reg == LAST_IDX) && (digit_val == 4'd0) && (state != ST_SET);
`else
    lz_blank = 1'b0;
`endif
    anode_next = ~(6'b000001 << idx_reg);
    seg_next   = (blink_blank || lz_blank) ? SEG_BLANK : seg_decoded;
    // Leading-zero blanking leaves dp alone; only the edit blink forces it off.
    dp_next    = blink_blank ? 1'b1 : !(is_colon(idx_reg) && (state != ST_RESET));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prescaler_reg   <= '0;
      idx_reg         <= 3'd0;
      frame_reg       <= 24'h000000;
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      anode_reg       <= 6'h3F;
      seg_reg         <= SEG_BLANK;
      dp_reg          <= 1'b1;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (tick) begin
        prescaler_reg <= '0;
        idx_reg       <= (idx_reg == LAST_IDX) ? 3'd0 : idx_reg + 3'd1;
        // Dead cycle between slots so the outgoing digit never ghosts into the next.
        anode_reg     <= 6'h3F;
        seg_reg       <= SEG_BLANK;
        dp_reg        <= 1'b1;
        if (idx_reg == LAST_IDX) begin
          frame_reg      <= currentBits;
          frame_done_reg <= 1'b1;
          if (frame_cnt_reg == FC_LAST) begin
            frame_cnt_reg   <= '0;
            blink_phase_reg <= !blink_phase_reg;
          end else begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
          end
        end
      end else begin
        prescaler_reg <= prescaler_reg + 1'b1;
        if (prescaler_reg == '0) begin
          anode_reg <= anode_next;
          seg_reg   <= seg_next;
          dp_reg    <= dp_next;
        end
      end
    end
  end

  assign anodeN    = anode_reg;
  assign segN      = seg_reg;
  assign dpN       = dp_reg;
  assign frameDone = frame_done_reg;

endmodule

// File: tb/tb_digit_display_scanner.sv
// Scoreboard bench for digit_display_scanner: expected slots are queued per frame
// and popped by a monitor at each slot start.
module tb_digit_display_scanner;

  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [3:0]  state = 4'd3;
  logic [23:0] currentBits = 24'h0;
  logic [2:0]  setSelect = 3'd7;
  logic [5:0]  anodeN;
  logic [6:0]  segN;
  logic        dpN;
  logic        frameDone;

  digit_display_scanner #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .state       (state),
    .currentBits (currentBits),
    .setSelect   (setSelect),
    .anodeN      (anodeN),
    .segN        (segN),
    .dpN         (dpN),
    .frameDone   (frameDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] anode;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int snaps;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) snaps <= 0;
    else if (frameDone) snaps <= snaps + 1;
  end

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic slot_t exp_slot(input logic [23:0] data, input int i,
                                     input logic [3:0] st, input logic [2:0] sel, input bit ph);
    slot_t s;
    logic [3:0] d;
    bit blank;
    bit lz;
    d = data[4*i +: 4];
    s.anode = 6'h3F;
    s.anode[i] = 1'b0;
    blank = (st == 4'd1) && (sel == 3'(i)) && ph;
    lz = 1'b0;
`ifdef DIGIT_DISPLAY_LZ_BLANK_EN
    lz = (i == 5) && (d == 4'd0) && (st != 4'd1);
`endif
    s.seg = (blank || lz) ? 7'h7F : ref_seg(d);
    s.dp = blank ? 1'b1 : ((((i == 2) || (i == 4)) && (st != 4'd0)) ? 1'b0 : 1'b1);
    return s;
  endfunction

  // Slot monitor: pops one expectation per slot start, then checks the slot length.
  logic [5:0] prev_anode = 6'h3F;
  int    hold = 0;
  bit    checking = 0;
  slot_t cur;
  always @(negedge clk) begin
    if (anodeN !== 6'h3F) begin
      if (prev_anode === 6'h3F) begin
        hold = 1;
        checking = 0;
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          checking = 1;
          total_cnt++;
          if ({anodeN, segN, dpN} !== cur) begin
            $display("FAIL slot: got anode=%h seg=%h dp=%b, expected anode=%h seg=%h dp=%b",
                     anodeN, segN, dpN, cur.anode, cur.seg, cur.dp);
          end else begin
            pass_cnt++;
            $display("slot anode=%h seg=%h dp=%b ok", anodeN, segN, dpN);
          end
        end
      end else begin
        hold++;
      end
    end else if ((prev_anode !== 6'h3F) && checking) begin
      checking = 0;
      total_cnt++;
      if (hold != SD - 1) $display("FAIL slot_hold: got %0d cycles, expected %0d", hold, SD - 1);
      else pass_cnt++;
    end
    prev_anode = anodeN;
  end

  // Waits for the next snapshot and queues the six slots of the frame it starts.
  task automatic expect_frame(input logic [23:0] data, output bit got);
    int n;
    n = 0;
    got = 0;
    while (n < 8 * SD) begin
      @(negedge clk);
      if (frameDone === 1'b1) break;
      n++;
    end
    if (frameDone === 1'b1) begin
      got = 1;
      for (int i = 0; i < 6; i++)
        sb.push_back(exp_slot(data, i, state, setSelect, bit'(((snaps + 1) / BF) % 2)));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10 * SD) begin
      @(negedge clk);
      n++;
    end
    repeat (SD) @(negedge clk);
  endtask

  task automatic test_reset();
    int cyc;
    resetN = 1'b0;
    state = 4'd3;
    setSelect = 3'd7;
    currentBits = 24'h123456;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (anodeN !== 6'h3F) $display("FAIL reset_anode: got %h, expected 3f", anodeN); else pass_cnt++;
    total_cnt++;
    if (segN !== 7'h7F) $display("FAIL reset_seg: got %h, expected 7f", segN); else pass_cnt++;
    total_cnt++;
    if (dpN !== 1'b1) $display("FAIL reset_dp: got %b, expected 1", dpN); else pass_cnt++;
    total_cnt++;
    if (frameDone !== 1'b0) $display("FAIL reset_frame_done: got %b, expected 0", frameDone); else pass_cnt++;
    for (int i = 0; i < 6; i++) sb.push_back(exp_slot(24'h0, i, state, setSelect, 1'b0));
    resetN = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (frameDone === 1'b1) break;
    end
    total_cnt++;
    if (cyc != 24) $display("FAIL first_frame_done: got cycle %0d, expected 24", cyc); else pass_cnt++;
    total_cnt++;
    if (sb.size() != 0) $display("FAIL zero_frame_drain: got %0d pending, expected 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_scan();
    bit got;
    expect_frame(24'h123456, got);
    total_cnt++;
    if (!got) $display("FAIL scan_frame_done: got none, expected pulse"); else pass_cnt++;
    wait_drain();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL scan_drain: got %0d pending, expected 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_midframe_change();
    bit got;
    expect_frame(24'h123456, got);
    total_cnt++;
    if (!got) $display("FAIL mid_frame_done: got none, expected pulse"); else pass_cnt++;
    repeat (2 * SD) @(negedge clk);
    currentBits = 24'h000000;
    wait_drain();
    expect_frame(24'h000000, got);
    total_cnt++;
    if (!got) $display("FAIL mid_next_frame_done: got none, expected pulse"); else pass_cnt++;
    wait_drain();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL mid_drain: got %0d pending, expected 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_blink();
    bit got;
    state = 4'd1;
    setSelect = 3'd2;
    currentBits = 24'h123456;
    for (int f = 0; f < 4; f++) begin
      expect_frame(currentBits, got);
      total_cnt++;
      if (!got) $display("FAIL blink_frame_done: got none, expected pulse (frame %0d)", f);
      else pass_cnt++;
      wait_drain();
    end
  endtask

  task automatic test_dash_and_modes();
    bit got;
    state = 4'd3;
    setSelect = 3'd7;
    currentBits = 24'hFA0000;
    expect_frame(currentBits, got);
    wait_drain();
    state = 4'd0;
    currentBits = 24'h123456;
    expect_frame(currentBits, got);
    wait_drain();
    state = 4'd3;
    currentBits = 24'h012345;
    expect_frame(currentBits, got);
    wait_drain();
    total_cnt++;
    if (!got || sb.size() != 0) $display("FAIL modes_drain: got %0d pending, expected 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n;
    int cyc;
    bit got;
    n = 0;
    while (anodeN === 6'h3F && n < 4 * SD) begin
      @(negedge clk);
      n++;
    end
    #2;
    resetN = 1'b0;
    #1;
    total_cnt++;
    if (anodeN !== 6'h3F) $display("FAIL async_anode: got %h, expected 3f", anodeN); else pass_cnt++;
    total_cnt++;
    if (segN !== 7'h7F) $display("FAIL async_seg: got %h, expected 7f", segN); else pass_cnt++;
    total_cnt++;
    if (dpN !== 1'b1) $display("FAIL async_dp: got %b, expected 1", dpN); else pass_cnt++;
    currentBits = 24'h987654;
    sb.delete();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) sb.push_back(exp_slot(24'h0, i, state, setSelect, 1'b0));
    resetN = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (frameDone === 1'b1) break;
    end
    total_cnt++;
    if (cyc != 24) $display("FAIL restart_frame_done: got cycle %0d, expected 24", cyc); else pass_cnt++;
    expect_frame(24'h987654, got);
    wait_drain();
    total_cnt++;
    if (!got || sb.size() != 0) $display("FAIL restart_drain: got %0d pending, expected 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_change();
    test_blink();
    test_dash_and_modes();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/digit_display_scanner.md
# digit_display_scanner

Reads the six packed BCD time digits produced by the per-digit counters (HH:MM:SS on `currentBits`) and drives a time-multiplexed, common-anode six-digit seven-segment display. Each frame latches a coherent snapshot, so a tick mid-scan never tears the displayed time. The selected digit blinks in set mode, and the colon decimal points are driven on the hour and minute boundaries. It sits between the digit counter chain and the board display pins, in the same `clk` domain as the one-second tick.

## Interface
- `SCAN_DIV`, 50000: `clk` cycles per digit slot (1 ms at 50 MHz); must be ≥ 2.
- `BLINK_FRAMES`, 64: frames per blink half-period.
- `clk`  in  1  system clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `state`  in  4  mode: 0 reset, 1 set, 3 start; other values are treated as start.
- `currentBits`  in  24  packed digits, [3:0] LSB (seconds units) … [23:20] HHB (hour tens).
- `setSelect`  in  3  digit index 0–5 being edited in set mode; values 6–7 mean none.
- `anodeN`  out  6  digit enables, active-low, bit i = digit i.
- `segN`  out  7  {g,f,e,d,c,b,a}, active-low.
- `dpN`  out  1  decimal point, active-low.
- `frameDone`  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- The prescaler counts 0..SCAN_DIV-1 and wraps. A tick is the cycle in which prescaler == SCAN_DIV-1.
- `idx` runs 0..5. On a tick, `idx` advances and wraps from 5 to 0.
- On a tick where `idx` is 5, the same edge does three things:
  - latches `frameReg <= currentBits`;
  - pulses `frameDone`;
  - increments the frame counter. When the counter reaches BLINK_FRAMES-1 it wraps to 0 and `blinkPhase` toggles.
- Digit value is `frameReg[4*idx+3 : 4*idx]`. It decodes as follows:
  - 0–9: standard patterns. 0 = 7'h40, 1 = 7'h79, 8 = 7'h00.
  - 10–15: dash, 7'h3F (g only).
- Blanking gives `segN` = 7'h7F and `dpN` = 1, with the anode still enabled. A digit is blanked when `state` == 1, `idx` == `setSelect`, and `blinkPhase` == 1.
- `dpN` = 0 when `idx` is 2 or 4 and `state` is not 0. Otherwise `dpN` = 1.
- Mode changes affect only blanking and dp, never the scan position.

## Timing
- All outputs are registered. The reset values (asynchronous, on `resetN` low) are:
  - `anodeN` = 6'h3F, `segN` = 7'h7F, `dpN` = 1, `frameDone` = 0;
  - prescaler, `idx`, `frameReg`, frame counter and `blinkPhase` all 0.
- Dead time: the edge ending a tick drives `anodeN` to 6'h3F (all off) for exactly one cycle.
- The following edge drives `anodeN` = ~(1<<idx) with the matching `segN`/`dpN`.
- Outputs then hold for the remaining SCAN_DIV-1 cycles of the slot.
- The first frame after reset displays 0s until the first snapshot. The first `frameDone` occurs 6·SCAN_DIV cycles after reset release.
- `currentBits` changing in any cycle other than the snapshot edge has no visible effect until the next frame.
- Reset asserted mid-slot forces the reset values immediately, without waiting for a clock edge. After release, scanning restarts at `idx` 0 with a fresh prescaler.
- `setSelect` and `state` are sampled every cycle. A change is visible at the next registered output update, which is either the dead-time or the slot-start edge.

## Configuration
- `DIGIT_DISPLAY_LZ_BLANK_EN`:
  - Defined: digit 5 (hour tens) is blanked when its snapshot value is 0 and `state` ≠ 1. `dpN` follows normal rules.
  - Undefined: digit 5 always shows its decoded value.

## Structure
- Package `digit_display_pkg` holds:
  - mode constants `ST_RESET`=4'd0, `ST_SET`=4'd1, `ST_START`=4'd3;
  - segment constants `SEG_BLANK`, `SEG_DASH`;
  - `NUM_DIGITS`=6;
  - colon positions (2, 4).
- Sub-module `bcd_to_seg7` is the pure combinational 4-bit → 7-bit active-low decoder, instantiated once on the muxed digit.

## Test plan
Use SCAN_DIV=4 and BLINK_FRAMES=2 in simulation.
- Reset then release with `currentBits`=24'h123456, `state`=3:
  - `frameDone` pulses at cycle 24;
  - the next frame shows `anodeN` 6'h3E with `segN` for 6, …, 6'h1F with `segN`=7'h79 (1);
  - a dead cycle of 6'h3F precedes each slot.
- Change `currentBits` to 24'h000000 mid-frame: the current frame still shows 123456, and the next frame shows zeros.
- `state`=1, `setSelect`=2: digit 2 alternates between its decoded value and 7'h7F every 2 frames. Other digits are steady, and digit 2 `dpN` is 1 while blanked.
- `currentBits`=24'hFA0000: digits 4 and 5 show 7'h3F (dash).
- With `DIGIT_DISPLAY_LZ_BLANK_EN` and 24'h012345 in `state` 3, digit 5 `segN`=7'h7F. With the macro undefined, digit 5 `segN`=7'h40.
- Assert `resetN` mid-slot: `anodeN`=6'h3F and `segN`=7'h7F the same cycle with no clock edge. After release, `idx` 0 is scanned first.
